uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the 115 200 Bd UART transmitter among NUM_REQ byte-stream requesters (e.g. command responder, telemetry, debug console). Each requester offers bytes on a valid/ready interface; the scheduler grants one requester at a time, holds the grant for a packet (up to MAX_BURST bytes), and drives the UART's send/busy handshake. A watchdog aborts a byte whose send is never acknowledged.

## Interface

- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 16, max bytes per grant before forced rotation (>=1)
- SEND_TIMEOUT, 1023, cycles to wait for ipTxBusy high after opTxSend rises (must exceed UART CLOCK_DIV, 434)

- ipClk  in  1  system clock, 50 MHz
- ipReset  in  1  asynchronous, active-high reset
- ipReqData  in  8*NUM_REQ  byte from requester i at bits [8i+7:8i]
- ipReqValid  in  NUM_REQ  requester i has a byte; held until accepted
- ipReqLast  in  NUM_REQ  byte on requester i is last of its packet
- opReqReady  out  NUM_REQ  byte of requester i accepted on this edge when valid
- opTxData  out  8  to UART ipTxData
- opTxSend  out  1  to UART ipTxSend
- ipTxBusy  in  1  from UART opTxBusy
- opGrant  out  NUM_REQ  one-hot current owner, zero when none
- opTimeout  out  1  one-cycle pulse on watchdog abort

## Operation

- States: IDLE, LOAD, WAIT_IDLE, SEND.
- IDLE: if any ipReqValid, grant first valid requester strictly after last owner (pointer), wrapping; set opGrant, clear byte count, -> LOAD. Else stay.
- LOAD: opReqReady = opGrant (combinational from state/grant). If granted valid: latch byte into opTxData, latch last flag, count+1, -> WAIT_IDLE. If valid low: release grant, update pointer, -> IDLE.
- WAIT_IDLE: when ipTxBusy low, opTxSend <= 1, clear watchdog, -> SEND.
- SEND: when ipTxBusy high, opTxSend <= 0; if last flag or count == MAX_BURST, release grant, pointer <= owner, -> IDLE; else -> LOAD.
- Watchdog: in SEND counts cycles; at SEND_TIMEOUT without ipTxBusy high: opTxSend <= 0, opTimeout pulse, release grant, pointer <= owner, -> IDLE. Byte is dropped, not retried.
- Grant changes only in IDLE or on release; a requester dropping or changing ipReqValid of a non-granted index has no effect.
- opTxData stable from LOAD accept until next accept.
- Reset: state IDLE, opGrant 0, opTxSend 0, opTxData 0, opTimeout 0, pointer = NUM_REQ-1 (requester 0 wins first), counters 0. Reset mid-send drops opTxSend immediately; partial packet abandoned.

## Timing

- Requester valid sampled in IDLE at edge k: opGrant at k, opReqReady high cycle after k, byte accepted edge k+1, opTxSend high after edge k+2 if UART idle.
- opTxSend high until first edge sampling ipTxBusy high; with UART clock enable every 434 cycles, up to 434 cycles.
- Between bytes of one packet: after busy high, LOAD next edge; opTxSend re-asserts only after busy falls (one full UART frame).
- Grant gap: release to next grant 1 cycle (IDLE).
- Byte count width clog2(MAX_BURST+1); compare is exact equality, no wrap.
- opTimeout exactly one cycle, same edge as opTxSend falls.

## Test plan

- Single requester 0 sends 0x55 with last, UART model idle -> opGrant=0001, ready one cycle, opTxSend high until busy rises, opTxData=0x55, grant released, back to IDLE.
- Requesters 0,1,2 all valid with 2-byte packets simultaneously -> serviced order 0,1,2; next round starts at 0 after 2; UART sees 6 bytes in order.
- Requester 3 streams 20 bytes never asserting last, MAX_BURST=16, requester 1 valid -> 16 bytes from 3, then 1's packet, then remaining 4 from 3.
- UART model never raises busy -> opTimeout pulses after 1023 cycles in SEND, opTxSend low, grant released, next requester served.
- Assert ipReset while opTxSend high mid-packet -> all outputs 0 immediately; after release, requester 0 granted first.
- Granted requester drops valid before last in LOAD -> grant released, pointer advanced, no opTxSend.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
//   Bundles the requester byte streams and the UART send/busy handshake
//   that connect to uart_tx_scheduler.
//
//   ipReqData   8*NUM_REQ  byte from requester i at bits [8i+7:8i]
//   ipReqValid  NUM_REQ    requester i has a byte
//   ipReqLast   NUM_REQ    byte on requester i ends its packet
//   opReqReady  NUM_REQ    byte of requester i accepted on this edge
//   opTxData    8          byte to the UART
//   opTxSend    1          send strobe to the UART
//   ipTxBusy    1          UART busy
//   opGrant     NUM_REQ    one-hot current owner
//   opTimeout   1          one-cycle watchdog abort pulse
//
//   slave  : scheduler side
//   master : requesters + UART side
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [8*NUM_REQ-1:0] ipReqData;
    logic [NUM_REQ-1:0]   ipReqValid;
    logic [NUM_REQ-1:0]   ipReqLast;
    logic [NUM_REQ-1:0]   opReqReady;
    logic [7:0]           opTxData;
    logic                 opTxSend;
    logic                 ipTxBusy;
    logic [NUM_REQ-1:0]   opGrant;
    logic                 opTimeout;

    modport slave (
        input  ipReqData,
        input  ipReqValid,
        input  ipReqLast,
        input  ipTxBusy,
        output opReqReady,
        output opTxData,
        output opTxSend,
        output opGrant,
        output opTimeout
    );

    modport master (
        output ipReqData,
        output ipReqValid,
        output ipReqLast,
        output ipTxBusy,
        input  opReqReady,
        input  opTxData,
        input  opTxSend,
        input  opGrant,
        input  opTimeout
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
//   streams. The owner keeps the grant for one packet or MAX_BURST bytes,
//   whichever ends first. A watchdog abandons a byte whose send strobe is
//   never answered by the UART raising busy.
//
//   ipClk    system clock
//   ipReset  asynchronous active-high reset
//   bus      uart_tx_scheduler_if.slave (requester streams, UART handshake,
//            grant and timeout status)
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int SEND_TIMEOUT = 1023
) (
    input  logic                         ipClk,
    input  logic                         ipReset,
    uart_tx_scheduler_if.slave           bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int WDG_W = $clog2(SEND_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_IDLE = 2'd2,
        SEND      = 2'd3
    } stateT;

    stateT              stateR,   stateNxt;
    logic [NUM_REQ-1:0] grantR,   grantNxt;
    logic [IDX_W-1:0]   ownerR,   ownerNxt;
    logic [IDX_W-1:0]   ptrR,     ptrNxt;
    logic [7:0]         txDataR,  txDataNxt;
    logic               txSendR,  txSendNxt;
    logic               timeoutR, timeoutNxt;
    logic               lastR,    lastNxt;
    logic [CNT_W-1:0]   countR,   countNxt;
    logic [WDG_W-1:0]   wdogR,    wdogNxt;

    logic [IDX_W-1:0]   candIdx;
    logic [IDX_W-1:0]   pickIdx;
    logic               ownerValid;
    logic               ownerLast;
    logic [7:0]         ownerData;

    // Round-robin pick: scan from farthest to nearest so the first valid
    // requester after the pointer is the one left in pickIdx.
    always_comb begin
        candIdx = '0;
        pickIdx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            candIdx = IDX_W'((int'(ptrR) + off) % NUM_REQ);
            pickIdx = bus.ipReqValid[candIdx] ? candIdx : pickIdx;
        end
    end

    // Current owner's stream, selected by the stored owner index.
    always_comb begin
        ownerValid = bus.ipReqValid[ownerR];
        ownerLast  = bus.ipReqLast[ownerR];
        ownerData  = bus.ipReqData[{ownerR, 3'b000} +: 8];
    end

    // Next-state and next-register logic for the scheduler FSM.
    always_comb begin
        stateNxt   = stateR;
        grantNxt   = grantR;
        ownerNxt   = ownerR;
        ptrNxt     = ptrR;
        txDataNxt  = txDataR;
        txSendNxt  = txSendR;
        timeoutNxt = 1'b0;
        lastNxt    = lastR;
        countNxt   = countR;
        wdogNxt    = wdogR;
        case (stateR)
            IDLE: begin
                if (|bus.ipReqValid) begin
                    grantNxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pickIdx;
                    ownerNxt = pickIdx;
                    countNxt = '0;
                    stateNxt = LOAD;
                end else begin
                    stateNxt = IDLE;
                end
            end
            LOAD: begin
                if (ownerValid) begin
                    txDataNxt = ownerData;
                    lastNxt   = ownerLast;
                    countNxt  = countR + CNT_W'(1);
                    stateNxt  = WAIT_IDLE;
                end else begin
                    // Owner went quiet mid-packet: give the UART to the next one.
                    grantNxt = '0;
                    ptrNxt   = ownerR;
                    stateNxt = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!bus.ipTxBusy) begin
                    txSendNxt = 1'b1;
                    wdogNxt   = '0;
                    stateNxt  = SEND;
                end else begin
                    stateNxt = WAIT_IDLE;
                end
            end
            SEND: begin
                if (bus.ipTxBusy) begin
                    txSendNxt = 1'b0;
                    if (lastR || (countR == CNT_W'(MAX_BURST))) begin
                        grantNxt = '0;
                        ptrNxt   = ownerR;
                        stateNxt = IDLE;
                    end else begin
                        stateNxt = LOAD;
                    end
                end else if (wdogR == WDG_W'(SEND_TIMEOUT - 1)) begin
                    // UART never answered: drop the byte, do not retry.
                    txSendNxt  = 1'b0;
                    timeoutNxt = 1'b1;
                    grantNxt   = '0;
                    ptrNxt     = ownerR;
                    stateNxt   = IDLE;
                end else begin
                    wdogNxt = wdogR + WDG_W'(1);
                end
            end
            default: begin
                txSendNxt = 1'b0;
                grantNxt  = '0;
                stateNxt  = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            stateR   <= IDLE;
            grantR   <= '0;
            ownerR   <= '0;
            ptrR     <= IDX_W'(NUM_REQ - 1);
            txDataR  <= 8'h00;
            txSendR  <= 1'b0;
            timeoutR <= 1'b0;
            lastR    <= 1'b0;
            countR   <= '0;
            wdogR    <= '0;
        end else begin
            stateR   <= stateNxt;
            grantR   <= grantNxt;
            ownerR   <= ownerNxt;
            ptrR     <= ptrNxt;
            txDataR  <= txDataNxt;
            txSendR  <= txSendNxt;
            timeoutR <= timeoutNxt;
            lastR    <= lastNxt;
            countR   <= countNxt;
            wdogR    <= wdogNxt;
        end
    end

    assign bus.opReqReady = (stateR == LOAD) ? grantR : '0;
    assign bus.opGrant    = grantR;
    assign bus.opTxData   = txDataR;
    assign bus.opTxSend   = txSendR;
    assign bus.opTimeout  = timeoutR;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler: requester queues, a UART model
//   that raises busy a few cycles after the send strobe (or never), and a
//   log of every byte the UART takes together with the grant at that time.
module tb_uart_tx_scheduler;

    logic ipClk;
    logic ipReset;

    uart_tx_scheduler_if #(.NUM_REQ(4)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(4),
        .MAX_BURST(16),
        .SEND_TIMEOUT(1023)
    ) dut (
        .ipClk(ipClk),
        .ipReset(ipReset),
        .bus(bus)
    );

    logic [8:0] reqQ[4][$];
    logic [7:0] logData[$];
    logic [3:0] logGrant[$];
    bit         neverBusy;
    int         passCount;
    int         failCount;
    int         totalCount;

    initial begin
        ipClk = 1'b0;
        forever #5 ipClk = ~ipClk;
    end

    // Requester queues and UART model.
    initial begin : env
        logic [3:0] accN;
        int busyCnt;
        int dly;
        bus.ipReqValid = 4'b0000;
        bus.ipReqLast  = 4'b0000;
        bus.ipReqData  = 32'h0;
        bus.ipTxBusy   = 1'b0;
        busyCnt = 0;
        dly = 0;
        forever begin
            @(negedge ipClk);
            accN = bus.opReqReady & bus.ipReqValid;
            @(posedge ipClk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (accN[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
            end
            if (busyCnt > 0) begin
                busyCnt--;
                if (busyCnt == 0) bus.ipTxBusy = 1'b0;
            end else if (bus.opTxSend && !neverBusy) begin
                if (dly == 2) begin
                    bus.ipTxBusy = 1'b1;
                    busyCnt = 8;
                    dly = 0;
                    logData.push_back(bus.opTxData);
                    logGrant.push_back(bus.opGrant);
                end else begin
                    dly++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (reqQ[i].size() > 0) begin
                    bus.ipReqValid[i]       = 1'b1;
                    bus.ipReqLast[i]        = reqQ[i][0][8];
                    bus.ipReqData[i*8 +: 8] = reqQ[i][0][7:0];
                end else begin
                    bus.ipReqValid[i]       = 1'b0;
                    bus.ipReqLast[i]        = 1'b0;
                    bus.ipReqData[i*8 +: 8] = 8'h00;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) begin
            passCount = passCount + 1;
        end else begin
            failCount = failCount + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ipClk);
        #2;
    endtask

    task automatic waitLog(input int n, input string tag);
        int budget;
        budget = 0;
        while (logData.size() < n && budget < 2000) begin
            tick();
            budget++;
        end
        check(tag, logData.size(), n);
    endtask

    task automatic waitSend(input string tag);
        int budget;
        budget = 0;
        while (bus.opTxSend !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        check(tag, bus.opTxSend, 1);
    endtask

    initial begin : main
        logic [7:0] t2Data[6];
        logic [3:0] t2Grant[6];
        int cnt;
        t2Data  = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1};
        t2Grant = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
        passCount = 0;
        failCount = 0;
        totalCount = 0;
        neverBusy = 1'b0;
        ipReset = 1'b1;
        repeat (3) @(posedge ipClk);
        #2;

        // Reset state
        check("rst_grant",   bus.opGrant,    0);
        check("rst_send",    bus.opTxSend,   0);
        check("rst_data",    bus.opTxData,   0);
        check("rst_timeout", bus.opTimeout,  0);
        check("rst_ready",   bus.opReqReady, 0);
        @(negedge ipClk);
        ipReset = 1'b0;
        tick();

        // Single byte 0x55 from requester 0
        reqQ[0].push_back({1'b1, 8'h55});
        tick();
        tick();
        check("t1_grant", bus.opGrant, 4'b0001);
        check("t1_ready", bus.opReqReady, 4'b0001);
        tick();
        check("t1_ready_low", bus.opReqReady, 0);
        check("t1_txdata", bus.opTxData, 8'h55);
        check("t1_send_wait", bus.opTxSend, 0);
        tick();
        check("t1_send_high", bus.opTxSend, 1);
        waitLog(1, "t1_log");
        check("t1_log_data", logData[0], 8'h55);
        check("t1_log_grant", logGrant[0], 4'b0001);
        tick();
        check("t1_send_drop", bus.opTxSend, 0);
        check("t1_release", bus.opGrant, 0);

        // Pointer back to requester 0
        @(negedge ipClk);
        ipReset = 1'b1;
        @(negedge ipClk);
        ipReset = 1'b0;
        tick();

        // Three 2-byte packets at once: order 0,1,2 then wrap to 0
        reqQ[0].push_back({1'b0, 8'hA0});
        reqQ[0].push_back({1'b1, 8'hA1});
        reqQ[1].push_back({1'b0, 8'hB0});
        reqQ[1].push_back({1'b1, 8'hB1});
        reqQ[2].push_back({1'b0, 8'hC0});
        reqQ[2].push_back({1'b1, 8'hC1});
        waitLog(7, "t2_log");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_data%0d", i), logData[1+i], t2Data[i]);
            check($sformatf("t2_grant%0d", i), logGrant[1+i], t2Grant[i]);
        end
        reqQ[0].push_back({1'b1, 8'hD0});
        reqQ[1].push_back({1'b1, 8'hE0});
        waitLog(9, "t2_round2_log");
        check("t2_r2_first", logGrant[7], 4'b0001);
        check("t2_r2_first_data", logData[7], 8'hD0);
        check("t2_r2_second", logGrant[8], 4'b0010);

        // Burst limit: requester 3 streams 20 bytes, requester 1 waits
        for (int i = 0; i < 20; i++) reqQ[3].push_back({1'b0, 8'(8'h30 + i)});
        reqQ[1].push_back({1'b0, 8'h10});
        reqQ[1].push_back({1'b1, 8'h11});
        waitLog(31, "t3_log");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t3_burst_data%0d", i), logData[9+i], 8'(8'h30 + i));
            check($sformatf("t3_burst_grant%0d", i), logGrant[9+i], 4'b1000);
        end
        check("t3_r1_data0", logData[25], 8'h10);
        check("t3_r1_data1", logData[26], 8'h11);
        check("t3_r1_grant", logGrant[26], 4'b0010);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_tail_data%0d", i), logData[27+i], 8'(8'h40 + i));
            check($sformatf("t3_tail_grant%0d", i), logGrant[27+i], 4'b1000);
        end
        repeat (12) tick();
        check("t3_idle_grant", bus.opGrant, 0);
        check("t3_no_extra", logData.size(), 31);

        // Granted requester drops valid before last
        reqQ[2].push_back({1'b0, 8'h77});
        waitLog(32, "t6_log");
        check("t6_grant_byte", logGrant[31], 4'b0100);
        tick();
        check("t6_load_grant", bus.opGrant, 4'b0100);
        check("t6_load_ready", bus.opReqReady, 4'b0100);
        tick();
        check("t6_release", bus.opGrant, 0);
        check("t6_no_send", bus.opTxSend, 0);
        reqQ[2].push_back({1'b1, 8'h66});
        reqQ[3].push_back({1'b1, 8'h67});
        waitLog(34, "t6_next_log");
        check("t6_ptr_data", logData[32], 8'h67);
        check("t6_ptr_grant", logGrant[32], 4'b1000);
        check("t6_after_grant", logGrant[33], 4'b0100);
        repeat (12) tick();

        // Watchdog: UART never raises busy
        neverBusy = 1'b1;
        reqQ[0].push_back({1'b1, 8'h99});
        reqQ[1].push_back({1'b1, 8'h88});
        waitSend("t4_send_rise");
        check("t4_grant", bus.opGrant, 4'b0001);
        cnt = 0;
        while (bus.opTimeout !== 1'b1 && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("t4_cycles", cnt, 1023);
        check("t4_send_low", bus.opTxSend, 0);
        check("t4_release", bus.opGrant, 0);
        neverBusy = 1'b0;
        tick();
        check("t4_pulse_end", bus.opTimeout, 0);
        check("t4_next_grant", bus.opGrant, 4'b0010);
        waitLog(35, "t4_log");
        check("t4_next_data", logData[34], 8'h88);
        repeat (12) tick();

        // Reset while opTxSend is high mid-packet
        neverBusy = 1'b1;
        reqQ[1].push_back({1'b0, 8'h21});
        reqQ[1].push_back({1'b1, 8'h22});
        waitSend("t5_send_rise");
        #1;
        ipReset = 1'b1;
        #1;
        check("t5_send",    bus.opTxSend,   0);
        check("t5_grant",   bus.opGrant,    0);
        check("t5_data",    bus.opTxData,   0);
        check("t5_timeout", bus.opTimeout,  0);
        check("t5_ready",   bus.opReqReady, 0);
        reqQ[0].push_back({1'b1, 8'h05});
        neverBusy = 1'b0;
        @(posedge ipClk);
        @(negedge ipClk);
        ipReset = 1'b0;
        tick();
        check("t5_first_grant", bus.opGrant, 4'b0001);
        waitLog(37, "t5_log");
        check("t5_data0", logData[35], 8'h05);
        check("t5_data1", logData[36], 8'h22);
        check("t5_grant1", logGrant[36], 4'b0010);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
